// File: rtl/alarm_pkg.sv
// Shared types and default constants for the sensor alarm front end.
package alarm_pkg;

  typedef enum logic {
    T_NORMAL = 1'b0,
    T_ALARM  = 1'b1
  } temp_state_t;

  localparam int TEMP_HI_DEF    = 60;
  localparam int TEMP_LO_DEF    = 55;
  localparam int TEMP_N_DEF     = 4;
  localparam int DEB_CYCLES_DEF = 16;
  localparam int TIMEOUT_DEF    = 1000;

endpackage

// File: rtl/sensor_alarm_conditioner_if.sv
// Temperature sample bus between the sensor sampler and the alarm conditioner.
// Handshake: a sample is accepted on every CLK edge where TEMP_VALID is 1 (no
// back-pressure); TEMP_ACK is a registered one-cycle pulse in the following cycle.
interface sensor_alarm_conditioner_if;
  logic [7:0] TEMP_DATA;
  logic       TEMP_VALID;
  logic       TEMP_ACK;

  modport master (output TEMP_DATA, output TEMP_VALID, input  TEMP_ACK);
  modport slave  (input  TEMP_DATA, input  TEMP_VALID, output TEMP_ACK);
endinterface

// File: rtl/alarm_debounce.sv
// Two-flop synchronizer followed by a consecutive-disagreement debounce counter.
module alarm_debounce
  import alarm_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level
);

  localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

  logic [1:0] sync_q;
  logic [7:0] cnt_q;

  // The level only toggles after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level <= ~level;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sensor_alarm_conditioner.sv
// Produces debounced HUMO/SOBRECARGA flags and a hysteretic, watchdog-protected
// TEMP flag for the downstream alarm state machine.
module sensor_alarm_conditioner
  import alarm_pkg::*;
#(
  parameter int         DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic [7:0] TEMP_HI    = 8'(TEMP_HI_DEF),
  parameter logic [7:0] TEMP_LO    = 8'(TEMP_LO_DEF),
  parameter int         TEMP_N     = TEMP_N_DEF,
  parameter int         TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         SMOKE_RAW,
  input  logic                         OVL_RAW,
  sensor_alarm_conditioner_if.slave    temp_bus,
  output logic                         HUMO,
  output logic                         SOBRECARGA,
  output logic                         TEMP,
  output logic                         FAULT,
  output temp_state_t                  T_STATE
);

  localparam int               WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [3:0]       QCNT_TGT = 4'(TEMP_N);

  alarm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_smoke_deb (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (SMOKE_RAW),
    .level (HUMO)
  );

  alarm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ovl_deb (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (OVL_RAW),
    .level (SOBRECARGA)
  );

  temp_state_t     state_q, state_d;
  logic [3:0]      qcnt_q, qcnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            ack_q, temp_q, fault_q;
  logic            temp_d, fault_d;
  logic            qualifies;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= T_NORMAL;
      qcnt_q  <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      temp_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      wd_q    <= wd_d;
      ack_q   <= temp_bus.TEMP_VALID;
      temp_q  <= temp_d;
      fault_q <= fault_d;
    end
  end

  // The qualifying direction depends on the current state: hot samples arm the
  // alarm, cool samples clear it, anything in the band restarts the run.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    wd_d      = wd_q;
    qualifies = (state_q == T_NORMAL) ? (temp_bus.TEMP_DATA >= TEMP_HI)
                                      : (temp_bus.TEMP_DATA <= TEMP_LO);
    if (temp_bus.TEMP_VALID) begin
      wd_d = '0;
      if (!qualifies) begin
        qcnt_d = '0;
      end else if (qcnt_q + 4'd1 == QCNT_TGT) begin
        state_d = (state_q == T_NORMAL) ? T_ALARM : T_NORMAL;
        qcnt_d  = '0;
      end else begin
        qcnt_d = qcnt_q + 4'd1;
      end
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // A stale stream forces TEMP high without disturbing the hysteresis state.
  always_comb begin
    fault_d = (wd_d == WD_MAX);
    temp_d  = fault_d | (state_d == T_ALARM);
  end

  assign temp_bus.TEMP_ACK = ack_q;
  assign TEMP              = temp_q;
  assign FAULT             = fault_q;
  assign T_STATE           = state_q;

endmodule

// File: tb/tb_sensor_alarm_conditioner.sv
// Directed bench for sensor_alarm_conditioner with a per-cycle reference model.
module tb_sensor_alarm_conditioner;
  import alarm_pkg::*;

  localparam int         DEB = 16;
  localparam int         TN  = 4;
  localparam int         TO  = 1000;
  localparam logic [7:0] HI  = 8'd60;
  localparam logic [7:0] LO  = 8'd55;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SMOKE_RAW = 1'b0;
  logic        OVL_RAW = 1'b0;
  logic        HUMO, SOBRECARGA, TEMP, FAULT;
  temp_state_t T_STATE;

  sensor_alarm_conditioner_if bus ();

  sensor_alarm_conditioner #(
    .DEB_CYCLES (DEB),
    .TEMP_HI    (HI),
    .TEMP_LO    (LO),
    .TEMP_N     (TN),
    .TIMEOUT    (TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SMOKE_RAW  (SMOKE_RAW),
    .OVL_RAW    (OVL_RAW),
    .temp_bus   (bus),
    .HUMO       (HUMO),
    .SOBRECARGA (SOBRECARGA),
    .TEMP       (TEMP),
    .FAULT      (FAULT),
    .T_STATE    (T_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int tests_run    = 0;
  int tests_failed = 0;
  bit started      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw contact history, newest sample in bit 0.
  logic [DEB+1:0] smk_hist = '0;
  logic [DEB+1:0] ovl_hist = '0;
  bit             m_humo = 0, m_sobre = 0, m_state = 0, m_ack = 0, m_fault = 0, m_temp = 0;
  int             gap = 0;
  logic [7:0]     samp_q[$];

  // A flag flips once the raw samples taken 2..DEB+1 edges ago all disagree with it.
  function automatic bit flips(input logic [DEB+1:0] h, input bit cur);
    for (int k = 2; k <= DEB + 1; k++) if (h[k] == cur) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit qualifies(input logic [7:0] s, input bit st);
    return st ? (s <= LO) : (s >= HI);
  endfunction

  task automatic model_step();
    if (RST) begin
      smk_hist = '0; ovl_hist = '0;
      m_humo = 0; m_sobre = 0; m_state = 0; m_ack = 0; m_fault = 0; m_temp = 0;
      gap = 0;
      samp_q.delete();
    end else begin
      smk_hist = {smk_hist[DEB:0], SMOKE_RAW};
      ovl_hist = {ovl_hist[DEB:0], OVL_RAW};
      if (flips(smk_hist, m_humo))  m_humo  = !m_humo;
      if (flips(ovl_hist, m_sobre)) m_sobre = !m_sobre;
      m_ack = bus.TEMP_VALID;
      if (bus.TEMP_VALID) begin
        gap = 0;
        samp_q.push_back(bus.TEMP_DATA);
        if (samp_q.size() >= TN) begin
          bit ok = 1'b1;
          for (int k = samp_q.size() - TN; k < samp_q.size(); k++)
            if (!qualifies(samp_q[k], m_state)) ok = 1'b0;
          if (ok) begin
            m_state = !m_state;
            samp_q.delete();
          end
        end
      end else begin
        gap++;
      end
      m_fault = (gap >= TO);
      m_temp  = m_state | m_fault;
    end
  endtask

  initial forever begin
    @(posedge CLK or posedge RST);
    model_step();
  end

  // ---------------- scoreboard compare ----------------
  initial forever begin
    @(negedge CLK);
    if (started) begin
      check("cyc_humo",   HUMO,         m_humo);
      check("cyc_sobre",  SOBRECARGA,   m_sobre);
      check("cyc_temp",   TEMP,         m_temp);
      check("cyc_fault",  FAULT,        m_fault);
      check("cyc_ack",    bus.TEMP_ACK, m_ack);
      check("cyc_tstate", T_STATE,      m_state);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_sample(input logic [7:0] d, output logic ack, output logic t, output logic f);
    bus.TEMP_DATA  = d;
    bus.TEMP_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.TEMP_VALID = 1'b0;
    ack = bus.TEMP_ACK;
    t   = TEMP;
    f   = FAULT;
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] seq_a [4] = '{8'd62, 8'd63, 8'd58, 8'd61};
  logic [7:0] seq_b [4] = '{8'd62, 8'd63, 8'd61, 8'd65};
  logic       exp_b [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] seq_c [6] = '{8'd56, 8'd57, 8'd50, 8'd50, 8'd50, 8'd50};
  logic       exp_c [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic ack, t, f;
    int   h_rise, s_rise, t_rise, ack_cnt;
    bit   sob_seen;

    bus.TEMP_DATA  = 8'd0;
    bus.TEMP_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_humo",  HUMO, 0);
    check("rst_sobre", SOBRECARGA, 0);
    check("rst_temp",  TEMP, 0);
    check("rst_fault", FAULT, 0);
    check("rst_ack",   bus.TEMP_ACK, 0);
    started = 1'b1;
    RST = 1'b0;

    // Smoke held high; 10-cycle overload glitch in parallel.
    SMOKE_RAW = 1'b1;
    h_rise = 0; sob_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      OVL_RAW = (i <= 10);
      @(posedge CLK);
      #1;
      if (HUMO && h_rise == 0) h_rise = i;
      if (SOBRECARGA) sob_seen = 1'b1;
    end
    check("humo_rise_edge", h_rise, 18);
    check("ovl_glitch_blocked", sob_seen, 0);
    idle(2);

    // 58 breaks the run of hot samples.
    for (int i = 0; i < 4; i++) begin
      send_sample(seq_a[i], ack, t, f);
      check("runA_ack", ack, 1);
      check("runA_temp", t, 0);
      idle(2);
    end
    send_sample(8'd20, ack, t, f);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      send_sample(seq_b[i], ack, t, f);
      check("runB_ack", ack, 1);
      check("runB_temp", t, exp_b[i]);
      idle(2);
    end
    for (int i = 0; i < 6; i++) begin
      send_sample(seq_c[i], ack, t, f);
      check("runC_temp", t, exp_c[i]);
      idle(2);
    end

    // Watchdog timeout and recovery.
    send_sample(8'd20, ack, t, f);
    check("wd_ref_temp", t, 0);
    idle(TO - 1);
    check("wd_fault_before", FAULT, 0);
    check("wd_temp_before", TEMP, 0);
    idle(1);
    check("wd_fault_at", FAULT, 1);
    check("wd_temp_failsafe", TEMP, 1);
    check("wd_state_kept", T_STATE, T_NORMAL);
    send_sample(8'd20, ack, t, f);
    check("wd_clear_ack", ack, 1);
    check("wd_clear_fault", f, 0);
    check("wd_clear_temp", t, 0);
    idle(TO - 1);
    send_sample(8'd20, ack, t, f);
    check("wd_valid_wins_fault", f, 0);
    check("wd_valid_wins_ack", ack, 1);
    idle(2);

    // Reset in the middle of an overload debounce and a hot-sample run.
    OVL_RAW = 1'b1;
    for (int i = 0; i < 3; i++) send_sample(8'd70, ack, t, f);
    idle(9);
    check("pre_rst_sobre", SOBRECARGA, 0);
    check("pre_rst_temp", TEMP, 0);
    check("pre_rst_humo", HUMO, 1);
    RST = 1'b1;
    #1;
    check("mid_rst_humo", HUMO, 0);
    check("mid_rst_sobre", SOBRECARGA, 0);
    check("mid_rst_temp", TEMP, 0);
    check("mid_rst_fault", FAULT, 0);
    idle(2);
    RST = 1'b0;

    // All three channels move together after reset release.
    h_rise = 0; s_rise = 0; t_rise = 0; ack_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      bus.TEMP_DATA  = 8'd70;
      bus.TEMP_VALID = (i <= 4);
      @(posedge CLK);
      #1;
      if (HUMO && h_rise == 0)       h_rise = i;
      if (SOBRECARGA && s_rise == 0) s_rise = i;
      if (TEMP && t_rise == 0)       t_rise = i;
      if (bus.TEMP_ACK)              ack_cnt++;
    end
    bus.TEMP_VALID = 1'b0;
    check("sim_humo_rise", h_rise, 18);
    check("sim_sobre_rise", s_rise, 18);
    check("sim_temp_rise", t_rise, 4);
    check("sim_ack_count", ack_cnt, 4);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, failed=%0d", tests_failed);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/sensor_alarm_conditioner.md
Name: sensor_alarm_conditioner

Overview:
Sensor-side front end that produces the HUMO, TEMP and SOBRECARGA alarm flags consumed by the alarm state machine. It synchronizes and debounces the raw smoke and overload contacts. It applies consecutive-sample hysteresis to an 8-bit temperature stream and runs a watchdog on that stream. All three flags are clean, glitch-free registered levels, so the alarm FSM never sees chatter.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronized cycles needed to change HUMO or SOBRECARGA (range 2..255)
TEMP_HI, 8'd60, raise threshold in °C (sample >= TEMP_HI counts toward alarm)
TEMP_LO, 8'd55, clear threshold in °C (sample <= TEMP_LO counts toward clear); TEMP_LO < TEMP_HI
TEMP_N, 4, consecutive qualifying samples needed to change TEMP (range 1..15)
TIMEOUT, 1000, CLK cycles without TEMP_VALID before FAULT is raised

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
SMOKE_RAW  in  1  raw smoke detector contact, asynchronous
OVL_RAW  in  1  raw overload contact, asynchronous
TEMP_DATA  in  8  unsigned temperature sample in °C, qualified by TEMP_VALID
TEMP_VALID  in  1  one-cycle strobe, sample accepted every cycle it is high
TEMP_ACK  out  1  one-cycle pulse, registered, one cycle after an accepted sample
HUMO  out  1  debounced smoke alarm
SOBRECARGA  out  1  debounced overload alarm
TEMP  out  1  temperature alarm (hysteresis or fail-safe)
FAULT  out  1  temperature stream stale

Behaviour:
- Reset: all outputs are 0, all counters are 0, synchronizers are 0, the temperature FSM is in T_NORMAL and the watchdog counter is 0. Reset has immediate effect mid-operation: partial debounce or hysteresis counts are discarded.
- Synchronizers: SMOKE_RAW and OVL_RAW each pass through two flops before any use.
- Debounce (per channel, identical):
  - When the synchronized input equals the output, the counter is cleared.
  - When they differ, the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1 while still differing, the output toggles on that edge and the counter clears.
  - Any single cycle of agreement restarts the count.
  - Net latency: a raw level held stable appears on the output exactly DEB_CYCLES+2 cycles after the first CLK edge that samples it.
  - A pulse shorter than DEB_CYCLES synchronized cycles never reaches the output.
- Temperature FSM, states T_NORMAL and T_ALARM, with a qualifying-sample counter qcnt (4 bits):
  - T_NORMAL, on a valid sample: if the sample >= TEMP_HI, qcnt increments; otherwise qcnt clears. When qcnt reaches TEMP_N, go to T_ALARM and clear qcnt.
  - T_ALARM, on a valid sample: if the sample <= TEMP_LO, qcnt increments; otherwise qcnt clears. When qcnt reaches TEMP_N, go to T_NORMAL and clear qcnt.
  - Samples between the two thresholds clear qcnt in both states.
  - Cycles with no valid sample leave qcnt unchanged; only samples count, not cycles.
  - The state change is registered on the edge that accepts the TEMP_N-th qualifying sample. TEMP reflects the new state one cycle later, in the same cycle as TEMP_ACK.
- Watchdog:
  - The counter clears on every TEMP_VALID and otherwise increments, saturating at TIMEOUT.
  - At TIMEOUT, FAULT goes to 1 and TEMP is forced to 1 (fail-safe). The FSM state is preserved.
  - The next TEMP_VALID clears FAULT one cycle later, in the same cycle as TEMP_ACK. TEMP then equals the FSM state.
  - If TEMP_VALID arrives in the same cycle the counter would reach TIMEOUT, the valid wins and FAULT stays 0.
- TEMP_ACK pulses once per accepted sample. Back-to-back valids give back-to-back ACKs.
- Channels are fully independent. Simultaneous transitions on all three are allowed and each is unaffected by the others.
- Counter widths are sized for their maximum count (8-bit debounce counter, 4-bit qcnt, 10-bit watchdog). Overflow cannot occur.

Decomposition:
- Shared package alarm_pkg holds:
  - the temperature state encoding (T_NORMAL=1'b0, T_ALARM=1'b1);
  - default threshold constants (TEMP_HI_DEF=60, TEMP_LO_DEF=55);
  - DEB_CYCLES_DEF=16 and TIMEOUT_DEF=1000.
- One sub-module, alarm_debounce (2-flop synchronizer plus debounce counter, parameter DEB_CYCLES), is instantiated twice, for smoke and overload.
- The temperature FSM and watchdog stay in the top level.

Test Plan:
- SMOKE_RAW 0->1 held: HUMO rises exactly 18 cycles after the first sampling edge. A 10-cycle glitch on OVL_RAW leaves SOBRECARGA at 0.
- Samples 62,63,61,65 with TEMP_VALID spaced 3 cycles apart: TEMP rises with the 4th TEMP_ACK. Samples 62,63,58,61 leave TEMP at 0 because 58 resets qcnt.
- From T_ALARM, samples 56,57,50,50,50,50: TEMP stays 1 through 56 and 57 (hysteresis band) and falls with the ACK of the 4th 50.
- No TEMP_VALID for 1000 cycles: FAULT=1 and TEMP=1 while the FSM is in T_NORMAL. One sample of 20 clears FAULT and returns TEMP to 0 in the ACK cycle.
- RST asserted mid-debounce (count 10) and mid-hysteresis (qcnt 3): all outputs go to 0 at once. After release, full DEB_CYCLES and TEMP_N are required again.
- SMOKE_RAW, OVL_RAW and over-threshold samples all applied together: HUMO, SOBRECARGA and TEMP each assert at their independent predicted cycles.
